// File: rtl/decode_stage.sv
// RV32/RV64 base-ISA decode stage: decodes the incoming word combinationally and
// queues the decoded fields in a small FIFO (1 or 2 entries) toward the execute stage.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [31:0]     s_instruction,
    input  logic [XLEN-1:0] s_pc,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [XLEN-1:0] m_pc,
    output logic [6:0]      m_opcode,
    output logic [6:0]      m_funct7,
    output logic [2:0]      m_funct3,
    output logic [XLEN-1:0] m_immediate,
    output logic [4:0]      m_rs1_raddr,
    output logic [4:0]      m_rs2_raddr,
    output logic [4:0]      m_rd_waddr,
    output logic [5:0]      m_format,
    output logic            m_illegal
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [6:0]      funct7;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [5:0]      fmt;
        logic            illegal;
    } entry_t;

    // ---------------------------------------------------------------- decode
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_r, is_i, is_s, is_b, is_u, is_j;
    logic        f7_std, shift_i, ill;
    logic [31:0] imm32;
    entry_t      dec;

    assign op = s_instruction[6:0];
    assign f3 = s_instruction[14:12];
    assign f7 = s_instruction[31:25];

    always_comb begin
        is_r    = (op == 7'b0110011);
        is_i    = (op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111});
        is_s    = (op == 7'b0100011);
        is_b    = (op == 7'b1100011);
        is_u    = (op inside {7'b0110111, 7'b0010111});
        is_j    = (op == 7'b1101111);
        f7_std  = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        shift_i = (op == 7'b0010011) && ((f3 == 3'b001) || (f3 == 3'b101));
        ill     = (s_instruction[1:0] != 2'b11)
               || !(is_r || is_i || is_s || is_b || is_u || is_j)
               || (is_r && !f7_std)
               || (shift_i && !f7_std);
    end

    always_comb begin
        imm32 = '0;
        if (is_i)
            imm32 = {{20{s_instruction[31]}}, s_instruction[31:20]};
        else if (is_s)
            imm32 = {{20{s_instruction[31]}}, s_instruction[31:25], s_instruction[11:7]};
        else if (is_b)
            imm32 = {{19{s_instruction[31]}}, s_instruction[31], s_instruction[7],
                     s_instruction[30:25], s_instruction[11:8], 1'b0};
        else if (is_u)
            imm32 = {s_instruction[31:12], 12'b0};
        else if (is_j)
            imm32 = {{11{s_instruction[31]}}, s_instruction[31], s_instruction[19:12],
                     s_instruction[20], s_instruction[30:21], 1'b0};
    end

    // Fields a format does not use are forced to zero; an illegal word keeps only pc/opcode.
    always_comb begin
        dec         = '0;
        dec.pc      = s_pc;
        dec.opcode  = op;
        dec.illegal = ill;
        if (!ill) begin
            dec.imm    = XLEN'($signed(imm32));
            dec.funct7 = (is_r || is_i) ? f7 : 7'd0;
            dec.funct3 = (is_u || is_j) ? 3'd0 : f3;
            dec.rs1    = (is_u || is_j) ? 5'd0 : s_instruction[19:15];
            dec.rs2    = (is_r || is_s || is_b) ? s_instruction[24:20] : 5'd0;
            dec.rd     = (is_s || is_b) ? 5'd0 : s_instruction[11:7];
            dec.fmt    = {is_j, is_u, is_b, is_s, is_i, is_r};
        end
    end

    // ---------------------------------------------------------------- buffer
    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic   [CW-1:0]    cnt_q, cnt_d;
    logic   [CW-1:0]    wr_idx;
    logic               push, pop;

    assign s_ready = (cnt_q < CW'(DEPTH));
    assign m_valid = (cnt_q != '0);
    assign push    = s_valid && s_ready && !flush;
    assign pop     = m_valid && m_ready && !flush;
    assign wr_idx  = cnt_q - CW'(pop);

    // Head always lives in slot 0; a pop shifts the queue down before the new write lands.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++)
                    mem_d[i] = mem_q[i+1];
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++)
                    if (wr_idx == CW'(i))
                        mem_d[i] = dec;
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            mem_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    entry_t head;

    assign head        = m_valid ? mem_q[0] : '0;
    assign m_pc        = head.pc;
    assign m_opcode    = head.opcode;
    assign m_funct7    = head.funct7;
    assign m_funct3    = head.funct3;
    assign m_immediate = head.imm;
    assign m_rs1_raddr = head.rs1;
    assign m_rs2_raddr = head.rs2;
    assign m_rd_waddr  = head.rd;
    assign m_format    = head.fmt;
    assign m_illegal   = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized check of decode_stage against a queue-based reference
// that decodes from the ISA rules directly.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk, rst, flush, s_valid, s_ready, m_valid, m_ready, m_illegal;
    logic [31:0]     s_instruction;
    logic [XLEN-1:0] s_pc, m_pc, m_immediate;
    logic [6:0]      m_opcode, m_funct7;
    logic [2:0]      m_funct3;
    logic [4:0]      m_rs1_raddr, m_rs2_raddr, m_rd_waddr;
    logic [5:0]      m_format;

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_instruction(s_instruction), .s_pc(s_pc),
        .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_opcode(m_opcode),
        .m_funct7(m_funct7), .m_funct3(m_funct3), .m_immediate(m_immediate),
        .m_rs1_raddr(m_rs1_raddr), .m_rs2_raddr(m_rs2_raddr), .m_rd_waddr(m_rd_waddr),
        .m_format(m_format), .m_illegal(m_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [5:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Format index: 0=R 1=I 2=S 3=B 4=U 5=J, -1 = unknown opcode.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   f, sw;
        logic bad;
        e = '0;
        e.pc = pc;
        e.op = w[6:0];
        case (w[6:0])
            7'h33:                             f = 0;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: f = 1;
            7'h23:                             f = 2;
            7'h63:                             f = 3;
            7'h37, 7'h17:                      f = 4;
            7'h6F:                             f = 5;
            default:                           f = -1;
        endcase
        bad = (w[1:0] != 2'b11) || (f < 0);
        if (w[6:0] == 7'h33 && !(w[31:25] == 7'h00 || w[31:25] == 7'h20)) bad = 1'b1;
        if (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5)
            && !(w[31:25] == 7'h00 || w[31:25] == 7'h20)) bad = 1'b1;
        if (bad) begin
            e.ill = 1'b1;
            return e;
        end
        sw = int'(w);
        case (f)
            1: e.imm = sw >>> 20;
            2: e.imm = ((sw >>> 25) << 5) | int'(w[11:7]);
            3: e.imm = ((sw >>> 31) << 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5)
                       | (int'(w[11:8]) << 1);
            4: e.imm = w & 32'hFFFF_F000;
            5: e.imm = ((sw >>> 31) << 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11)
                       | (int'(w[30:21]) << 1);
            default: e.imm = 32'd0;
        endcase
        e.fmt = 6'(1 << f);
        e.f7  = (f <= 1) ? w[31:25] : 7'd0;
        e.f3  = (f <= 3) ? w[14:12] : 3'd0;
        e.rs1 = (f <= 3) ? w[19:15] : 5'd0;
        e.rs2 = (f == 0 || f == 2 || f == 3) ? w[24:20] : 5'd0;
        e.rd  = (f == 2 || f == 3) ? 5'd0 : w[11:7];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        e = (q.size() != 0) ? q[0] : '0;
        chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
        chk("s_ready", 64'(s_ready), 64'(q.size() < DEPTH));
        chk("m_pc", 64'(m_pc), 64'(e.pc));
        chk("m_opcode", 64'(m_opcode), 64'(e.op));
        chk("m_funct7", 64'(m_funct7), 64'(e.f7));
        chk("m_funct3", 64'(m_funct3), 64'(e.f3));
        chk("m_immediate", 64'(m_immediate), 64'(e.imm));
        chk("m_rs1", 64'(m_rs1_raddr), 64'(e.rs1));
        chk("m_rs2", 64'(m_rs2_raddr), 64'(e.rs2));
        chk("m_rd", 64'(m_rd_waddr), 64'(e.rd));
        chk("m_format", 64'(m_format), 64'(e.fmt));
        chk("m_illegal", 64'(m_illegal), 64'(e.ill));
    endtask

    task automatic drive(input logic sv, input logic [31:0] w, input logic [31:0] pc,
                         input logic mr, input logic fl);
        s_valid = sv; s_instruction = w; s_pc = pc; m_ready = mr; flush = fl;
    endtask

    // One clock: update the model with the inputs the DUT sees, then check at the falling edge.
    task automatic tick();
        logic acc, pop;
        @(posedge clk);
        acc = s_valid && (q.size() < DEPTH) && !flush;
        pop = (q.size() != 0) && m_ready && !flush;
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(s_instruction, s_pc));
        end
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 12))
            0: w[6:0] = 7'h33;   1: w[6:0] = 7'h13;   2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h67;   4: w[6:0] = 7'h73;   5: w[6:0] = 7'h0F;
            6: w[6:0] = 7'h23;   7: w[6:0] = 7'h63;   8: w[6:0] = 7'h37;
            9: w[6:0] = 7'h17;  10: w[6:0] = 7'h6F;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_outputs();
        chk("reset_s_ready", 64'(s_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back ADDI x1,x2,-1 with m_ready high
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hFFF1_0093, 32'(i * 4), 1'b1, 1'b0);
            tick();
            chk("addi_valid", 64'(m_valid), 64'd1);
            chk("addi_pc", 64'(m_pc), 64'(i * 4));
            chk("addi_imm", 64'(m_immediate), 64'hFFFF_FFFF);
            chk("addi_rs1", 64'(m_rs1_raddr), 64'd2);
            chk("addi_rd", 64'(m_rd_waddr), 64'd1);
            chk("addi_fmt", 64'(m_format), 64'b000010);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();

        // BEQ then JAL
        drive(1'b1, 32'hFE20_8EE3, 32'h40, 1'b1, 1'b0);
        tick();
        chk("beq_imm", 64'(m_immediate), 64'hFFFF_FFFC);
        chk("beq_rd", 64'(m_rd_waddr), 64'd0);
        chk("beq_fmt", 64'(m_format), 64'b001000);
        drive(1'b1, 32'h0010_00EF, 32'h44, 1'b1, 1'b0);
        tick();
        chk("jal_imm", 64'(m_immediate), 64'h800);
        chk("jal_rs1", 64'(m_rs1_raddr), 64'd0);
        chk("jal_rs2", 64'(m_rs2_raddr), 64'd0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();

        // Backpressure: three offered, two held, third waits upstream
        drive(1'b1, 32'h0011_0113, 32'h100, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h0022_0213, 32'h104, 1'b0, 1'b0); tick();
        chk("bp_full_s_ready", 64'(s_ready), 64'd0);
        drive(1'b1, 32'h0033_0313, 32'h108, 1'b0, 1'b0); tick(); tick();
        chk("bp_stable_pc", 64'(m_pc), 64'h100);
        drive(1'b1, 32'h0033_0313, 32'h108, 1'b1, 1'b0); tick();
        chk("bp_order1", 64'(m_pc), 64'h104);
        tick();
        chk("bp_order2", 64'(m_pc), 64'h108);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0); tick();

        // Illegal words
        drive(1'b1, 32'h0000_0000, 32'h200, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h0000_007F, 32'h204, 1'b0, 1'b0); tick();
        chk("ill0_flag", 64'(m_illegal), 64'd1);
        chk("ill0_pc", 64'(m_pc), 64'h200);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0); tick();
        chk("ill7f_flag", 64'(m_illegal), 64'd1);
        chk("ill7f_op", 64'(m_opcode), 64'h7F);
        chk("ill7f_fields", 64'({m_immediate, m_funct7, m_funct3, m_format}), 64'd0);
        tick();

        // Flush with a full buffer and a word offered in the same cycle
        drive(1'b1, 32'h0011_0113, 32'h300, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h0022_0213, 32'h304, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h0033_0313, 32'h308, 1'b1, 1'b1); tick();
        chk("flush_valid", 64'(m_valid), 64'd0);
        chk("flush_s_ready", 64'(s_ready), 64'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0); tick();

        // Asynchronous reset between edges while holding an entry
        drive(1'b1, 32'h0011_0113, 32'h400, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(m_valid), 64'd0);
        chk("arst_s_ready", 64'(s_ready), 64'd1);
        rst = 1'b0;
        q.delete();
        drive(1'b1, 32'hFFF1_0093, 32'h500, 1'b1, 1'b0); tick();
        chk("arst_latency_pc", 64'(m_pc), 64'h500);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0); tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_word(), $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; legal values are 1 and 2.
REQ-003 SHALL use one clock and asynchronous active-high reset, as follows.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have the following ports:
- flush  in  1  drop all buffered entries.
- s_valid  in  1  upstream instruction valid.
- s_ready  out  1  stage can accept.
- s_instruction  in  32  raw instruction word.
- s_pc  in  XLEN  address of s_instruction.
- m_valid  out  1  decoded entry valid.
- m_ready  in  1  downstream accepts.
- m_pc  out  XLEN  address of the decoded instruction.
- m_opcode  out  7  opcode field.
- m_funct7  out  7  funct7 field.
- m_funct3  out  3  funct3 field.
- m_immediate  out  XLEN  sign-extended immediate.
- m_rs1_raddr, m_rs2_raddr, m_rd_waddr  out  5 each  register addresses.
- m_format  out  6  one-hot {J,U,B,S,I,R}.
- m_illegal  out  1  instruction not decodable.

Function
REQ-005 SHALL accept an entry on any edge where s_valid && s_ready && !flush.
REQ-006 SHALL pop the head entry on any edge where m_valid && m_ready && !flush.
REQ-007 SHALL drive s_ready = (count < DEPTH), computed from registered count only, with no combinational path from m_ready.
REQ-008 SHALL drive m_valid = (count != 0) and present the head entry on all m_* outputs.
REQ-009 SHALL present an accepted instruction on m_* in the cycle after acceptance when the buffer was empty, giving 1-cycle latency.
REQ-010 SHALL sustain one instruction per cycle when m_ready is held high.
REQ-011 SHALL, on simultaneous accept and pop, leave count unchanged and keep entries in FIFO order.
REQ-012 SHALL leave m_* outputs stable while m_valid && !m_ready.
REQ-013 SHALL, when flush is high, set count to 0 at the edge; flush has priority over accept and pop in the same cycle.
REQ-014 SHALL decode the following opcodes and formats:
- R: 0110011.
- I: 0010011, 0000011, 1100111, 1110011, 0001111.
- S: 0100011.
- B: 1100011.
- U: 0110111, 0010111.
- J: 1101111.
REQ-015 SHALL build immediates per the RISC-V base ISA, sign-extended from bit 31 to XLEN:
- I: inst[31:20].
- S: {inst[31:25], inst[11:7]}.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U: {inst[31:12], 12'b0}, sign-extended.
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
REQ-016 SHALL zero fields unused by a format:
- immediate for R.
- rs2 for I, U and J.
- rs1 for U and J.
- rd for S and B.
- funct3 for U and J.
- funct7 for all formats except R and I.
REQ-017 SHALL set m_illegal when any of the following holds:
- inst[1:0] != 2'b11.
- the opcode is not listed in REQ-014.
- the opcode is 0110011 and funct7 is not 0000000 or 0100000.
- the opcode is 0010011, funct3 is 001 or 101, and inst[31:25] is not 0000000 or 0100000.
REQ-018 SHALL, when m_illegal is set, zero m_immediate, the register addresses, m_format and the funct fields, while still passing m_pc and m_opcode.
REQ-019 SHALL perform decode before storage, so that stored entries hold decoded fields; the raw word is not stored.
REQ-020 SHALL hold DEPTH=1 behaviour identical, except that s_ready is low whenever count is 1.

Reset
REQ-021 SHALL, while rst is asserted, hold count = 0, m_valid = 0 and s_ready = 1, independent of clk.
REQ-022 SHALL drive all m_* data outputs to 0 while count is 0, both after reset and after flush.
REQ-023 SHALL, on rst asserted mid-transfer, discard all buffered entries, with no accept or pop completing on that edge.

Verification
REQ-024 Back-to-back ADDI x1,x2,-1 (0xFFF10093), PCs 0x0/0x4/0x8, m_ready=1 -> m_valid from cycle 1; m_immediate=0xFFFFFFFF; rs1=2; rd=1; format=I; one output per cycle.
REQ-025 BEQ x1,x2,-4 (0xFE208EE3) -> m_immediate=0xFFFFFFFC; rd=0; format=B. JAL x1,+2048 (0x001000EF) -> m_immediate=0x00000800; rs1=rs2=0.
REQ-026 m_ready=0, three instructions offered, DEPTH=2 -> two accepted; s_ready low after second; third held upstream; m_* stable; release m_ready -> FIFO order preserved.
REQ-027 Word 0x00000000, then word 0x0000007F -> m_illegal=1; immediate, register addresses, format and funct fields all zero; m_pc passed.
REQ-028 Buffer holding 2, flush with s_valid=1 in the same cycle -> next cycle count=0, m_valid=0, s_ready=1; offered word not accepted.
REQ-029 rst pulsed asynchronously between edges with m_valid=1 -> m_valid falls immediately; after release, the first accepted instruction appears with 1-cycle latency.
